// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync word, payload MSB-first, one gap bit.
// Ports: i_clock/i_reset, i_data/i_valid/o_ready handshake, o_A line, o_sync/o_busy/o_done status.
module seq_frame_tx #(
  parameter int                  SYNC_LEN  = 5,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = 5'b11010,
  parameter int                  DATA_W    = 8,
  parameter logic                IDLE_BIT  = 1'b0
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_A,
  output logic              o_sync,
  output logic              o_busy,
  output logic              o_done
);

  localparam int MAXL = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
  localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_GAP
  } state_t;

  state_t              state_q;
  logic [SYNC_LEN-1:0] sync_sr_q;
  logic [DATA_W-1:0]   data_sr_q;
  logic [CW-1:0]       cnt_q;
  logic                ready_q;
  logic                a_q;
  logic                sync_q;
  logic                busy_q;
  logic                done_q;

  // Both shift registers hold the bits still to be sent, next bit at MSB.
  // The counter tracks how many bits of the current field remain after
  // the one on the line now.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      sync_sr_q <= '0;
      data_sr_q <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      a_q       <= IDLE_BIT;
      sync_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          a_q <= IDLE_BIT;
          if (i_valid) begin
            state_q   <= S_SYNC;
            data_sr_q <= i_data;
            sync_sr_q <= SYNC_WORD << 1;
            a_q       <= SYNC_WORD[SYNC_LEN-1];
            cnt_q     <= CW'(SYNC_LEN - 1);
            sync_q    <= 1'b1;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
          end
        end
        S_SYNC: begin
          if (cnt_q == '0) begin
            state_q   <= S_DATA;
            a_q       <= data_sr_q[DATA_W-1];
            data_sr_q <= data_sr_q << 1;
            cnt_q     <= CW'(DATA_W - 1);
            sync_q    <= 1'b0;
          end else begin
            a_q       <= sync_sr_q[SYNC_LEN-1];
            sync_sr_q <= sync_sr_q << 1;
            cnt_q     <= cnt_q - CW'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == '0) begin
            state_q <= S_GAP;
            a_q     <= IDLE_BIT;
            done_q  <= 1'b1;
          end else begin
            a_q       <= data_sr_q[DATA_W-1];
            data_sr_q <= data_sr_q << 1;
            cnt_q     <= cnt_q - CW'(1);
          end
        end
        S_GAP: begin
          // Gap bit guarantees the receiver sees an idle level between frames.
          state_q <= S_IDLE;
          a_q     <= IDLE_BIT;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_A     = a_q;
  assign o_sync  = sync_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx: default and overridden framing,
// back-to-back frames, mid-frame handshake, async reset and loopback detection.
module tb_seq_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  logic       ready, a, sync, busy, done;
  logic [3:0] data2;
  logic       valid2;
  logic       ready2, a2, sync2, busy2, done2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_frame_tx dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_data (data),
    .i_valid(valid),
    .o_ready(ready),
    .o_A    (a),
    .o_sync (sync),
    .o_busy (busy),
    .o_done (done)
  );

  seq_frame_tx #(
    .SYNC_WORD(5'b10110),
    .DATA_W   (4)
  ) dut2 (
    .i_clock(clk),
    .i_reset(rst),
    .i_data (data2),
    .i_valid(valid2),
    .o_ready(ready2),
    .o_A    (a2),
    .o_sync (sync2),
    .o_busy (busy2),
    .o_done (done2)
  );

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; valid2 = 1'b0;
    data = '0; data2 = '0;
    #12;
    n_cmp++;
    if ({ready, a, sync, busy, done} !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_outs got %b exp 10000",
               {ready, a, sync, busy, done});
    end
    n_cmp++;
    if ({ready2, a2, sync2, busy2, done2} !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_outs2 got %b exp 10000",
               {ready2, a2, sync2, busy2, done2});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [13:0] ea;
    logic e;
    ea = 14'b11010_10100101_0;
    @(negedge clk);
    data = 8'hA5; valid = 1'b1;
    for (int t = 1; t <= 15; t++) begin
      @(negedge clk);
      valid = 1'b0;
      if (t <= 14) e = ea[14-t];
      else e = 1'b0;
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL single_A t=%0d got %b exp %b", t, a, e);
      end
      n_cmp++;
      if (sync !== (t <= 5)) begin
        n_bad++;
        $display("FAIL single_sync t=%0d got %b", t, sync);
      end
      n_cmp++;
      if (done !== (t == 14)) begin
        n_bad++;
        $display("FAIL single_done t=%0d got %b", t, done);
      end
      n_cmp++;
      if (ready !== (t == 15)) begin
        n_bad++;
        $display("FAIL single_ready t=%0d got %b", t, ready);
      end
      n_cmp++;
      if (busy !== (t <= 14)) begin
        n_bad++;
        $display("FAIL single_busy t=%0d got %b", t, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [28:0] ea;
    logic e;
    ea = 29'b11010_11111111_0_0_11010_00000000_0;
    @(negedge clk);
    data = 8'hFF; valid = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      if (t <= 29) e = ea[29-t];
      else e = 1'b0;
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL b2b_A t=%0d got %b exp %b", t, a, e);
      end
      n_cmp++;
      if (ready !== (t == 15 || t == 30)) begin
        n_bad++;
        $display("FAIL b2b_ready t=%0d got %b", t, ready);
      end
      n_cmp++;
      if (sync !== (t <= 5 || (t >= 16 && t <= 20))) begin
        n_bad++;
        $display("FAIL b2b_sync t=%0d got %b", t, sync);
      end
      n_cmp++;
      if (done !== (t == 14 || t == 29)) begin
        n_bad++;
        $display("FAIL b2b_done t=%0d got %b", t, done);
      end
      if (t == 7) data = 8'h00;
      if (t == 16) valid = 1'b0;
    end
  endtask

  task automatic test_ignore_midframe();
    logic [13:0] ea;
    logic e;
    ea = 14'b11010_10100101_0;
    @(negedge clk);
    data = 8'hA5; valid = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      @(negedge clk);
      if (t <= 14) e = ea[14-t];
      else e = 1'b0;
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL ignore_A t=%0d got %b exp %b", t, a, e);
      end
      n_cmp++;
      if (ready !== (t >= 15)) begin
        n_bad++;
        $display("FAIL ignore_ready t=%0d got %b", t, ready);
      end
      n_cmp++;
      if (busy !== (t <= 14)) begin
        n_bad++;
        $display("FAIL ignore_busy t=%0d got %b", t, busy);
      end
      if (t == 1) valid = 1'b0;
      if (t == 8) begin
        data = 8'h5A; valid = 1'b1;
      end
      if (t == 9) data = 8'h0F;
      if (t == 10) valid = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    logic [13:0] ea;
    logic e;
    @(negedge clk);
    data = 8'hA5; valid = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      @(negedge clk);
      valid = 1'b0;
    end
    n_cmp++;
    if (a !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL areset_pre got A=%b busy=%b exp 1 1", a, busy);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({ready, a, sync, busy, done} !== 5'b10000) begin
      n_bad++;
      $display("FAIL areset_now got %b exp 10000",
               {ready, a, sync, busy, done});
    end
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ready, a, busy} !== 3'b100) begin
      n_bad++;
      $display("FAIL areset_noresume got %b exp 100", {ready, a, busy});
    end
    ea = 14'b11010_00111100_0;
    data = 8'h3C; valid = 1'b1;
    for (int t = 1; t <= 15; t++) begin
      @(negedge clk);
      valid = 1'b0;
      if (t <= 14) e = ea[14-t];
      else e = 1'b0;
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL areset_frame_A t=%0d got %b exp %b", t, a, e);
      end
      n_cmp++;
      if (sync !== (t <= 5)) begin
        n_bad++;
        $display("FAIL areset_frame_sync t=%0d got %b", t, sync);
      end
    end
  endtask

  task automatic test_override();
    logic [9:0] ea;
    logic e;
    ea = 10'b10110_0011_0;
    @(negedge clk);
    data2 = 4'h3; valid2 = 1'b1;
    for (int t = 1; t <= 11; t++) begin
      @(negedge clk);
      valid2 = 1'b0;
      if (t <= 10) e = ea[10-t];
      else e = 1'b0;
      n_cmp++;
      if (a2 !== e) begin
        n_bad++;
        $display("FAIL ovr_A t=%0d got %b exp %b", t, a2, e);
      end
      n_cmp++;
      if (sync2 !== (t <= 5)) begin
        n_bad++;
        $display("FAIL ovr_sync t=%0d got %b", t, sync2);
      end
      n_cmp++;
      if (busy2 !== (t <= 10)) begin
        n_bad++;
        $display("FAIL ovr_busy t=%0d got %b", t, busy2);
      end
      n_cmp++;
      if (done2 !== (t == 10)) begin
        n_bad++;
        $display("FAIL ovr_done t=%0d got %b", t, done2);
      end
      n_cmp++;
      if (ready2 !== (t == 11)) begin
        n_bad++;
        $display("FAIL ovr_ready t=%0d got %b", t, ready2);
      end
    end
  endtask

  task automatic test_loopback();
    logic [4:0] det;
    logic hit;
    int hits;
    det = '0; hits = 0;
    @(negedge clk);
    data = 8'h00; valid = 1'b1;
    for (int t = 1; t <= 31; t++) begin
      @(negedge clk);
      det = {det[3:0], a};
      hit = (det == 5'b11010);
      if (hit) hits++;
      n_cmp++;
      if (hit !== (t == 5 || t == 20)) begin
        n_bad++;
        $display("FAIL loop_hit t=%0d got %b", t, hit);
      end
      if (hit) begin
        n_cmp++;
        if (sync !== 1'b1) begin
          n_bad++;
          $display("FAIL loop_sync t=%0d got %b exp 1", t, sync);
        end
      end
      if (t == 16) valid = 1'b0;
    end
    n_cmp++;
    if (hits != 2) begin
      n_bad++;
      $display("FAIL loop_count got %0d exp 2", hits);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_midframe();
    test_async_reset();
    test_override();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
